// File: rtl/iic_reg_sequencer.sv
// -----------------------------------------------------------------------------
// iic_reg_sequencer
//
// Purpose:
//   Turns one host register access (single-byte write or read) into the
//   ordered command/byte sequence the IIC byte engine expects:
//     write: START|WR {dev,0} -> WR reg -> WR|STOP wdata
//     read : START|WR {dev,0} -> WR reg -> START|WR {dev,1} -> RD|STOP
//   Each byte waits for the engine's done pulse; a missing done pulse within
//   TIMEOUT_CYC cycles aborts the access with an error response.
//
// Configuration macro:
//   IIC_SEQ_ADDR16_EN  - defined: two-byte register address (MSB first),
//                        one extra WR step in both sequences.
//                        undefined: one-byte register address, 2-bit step.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - host request handshake (ready only while idle)
//   req_rw            - 0 = write, 1 = read
//   req_dev_addr      - 7-bit device address
//   req_reg_addr      - register address ([15:8] used only with ADDR16)
//   req_wdata         - write data byte
//   rsp_valid         - one-cycle completion strobe
//   rsp_err           - timeout abort flag (with rsp_valid)
//   rsp_rdata         - read byte (0 on write or error)
//   eng_cmd_valid     - one-cycle command strobe to the byte engine
//   eng_cmd           - one-hot OR command (WR/START/RD/STOP)
//   eng_wdata         - byte to transmit, held until the next command
//   eng_done          - byte-engine completion pulse
//   eng_rdata         - byte-engine read data
// -----------------------------------------------------------------------------
module iic_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev_addr,
  input  logic [15:0] req_reg_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_rdata,
  output logic        eng_cmd_valid,
  output logic [5:0]  eng_cmd,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata
);

  localparam logic [5:0] CMD_WR    = 6'h01;
  localparam logic [5:0] CMD_START = 6'h02;
  localparam logic [5:0] CMD_RD    = 6'h04;
  localparam logic [5:0] CMD_STOP  = 6'h08;

`ifdef IIC_SEQ_ADDR16_EN
  localparam int unsigned STEP_W = 3;
  localparam int unsigned REG_W  = 16;
  localparam logic [STEP_W-1:0] LAST_WR = 3'd3;
  localparam logic [STEP_W-1:0] LAST_RD = 3'd4;
`else
  localparam int unsigned STEP_W = 2;
  localparam int unsigned REG_W  = 8;
  localparam logic [STEP_W-1:0] LAST_WR = 2'd2;
  localparam logic [STEP_W-1:0] LAST_RD = 2'd3;
`endif

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // The WAIT cycle holding this count is the last one allowed; the counter
  // starts at 0 in the first WAIT cycle after ISSUE.
  localparam logic [CNT_W-1:0]  CNT_TO   = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Command and byte for one step of the sequence: {cmd[5:0], byte[7:0]}.
  function automatic logic [13:0] step_cmd(
    input logic [STEP_W-1:0] step,
    input logic              rw,
    input logic [6:0]        dev,
    input logic [REG_W-1:0]  reg_addr,
    input logic [7:0]        wdata
  );
    logic [13:0] r;
    r = 14'h0000;
    case (step)
`ifdef IIC_SEQ_ADDR16_EN
      3'd0:    r = {CMD_START | CMD_WR, dev, 1'b0};
      3'd1:    r = {CMD_WR, reg_addr[15:8]};
      3'd2:    r = {CMD_WR, reg_addr[7:0]};
      3'd3:    r = rw ? {CMD_START | CMD_WR, dev, 1'b1} : {CMD_WR | CMD_STOP, wdata};
      3'd4:    r = {CMD_RD | CMD_STOP, 8'h00};
      default: r = 14'h0000;
`else
      2'd0:    r = {CMD_START | CMD_WR, dev, 1'b0};
      2'd1:    r = {CMD_WR, reg_addr[7:0]};
      2'd2:    r = rw ? {CMD_START | CMD_WR, dev, 1'b1} : {CMD_WR | CMD_STOP, wdata};
      2'd3:    r = {CMD_RD | CMD_STOP, 8'h00};
      default: r = 14'h0000;
`endif
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [6:0]         dev_q, dev_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;

  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic               eng_cmd_valid_q, eng_cmd_valid_d;
  logic [5:0]         eng_cmd_q, eng_cmd_d;
  logic [7:0]         eng_wdata_q, eng_wdata_d;

  logic [STEP_W-1:0]  last_step_s;
  logic [13:0]        step_word_s;

`ifndef IIC_SEQ_ADDR16_EN
  // Upper register-address byte has no function in the one-byte build.
  logic unused_reg_hi_s;
  assign unused_reg_hi_s = ^req_reg_addr[15:8];
`endif

  assign last_step_s = rw_q ? LAST_RD : LAST_WR;

  // Next-state, step/counter and request-latch logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          rw_d    = req_rw;
          dev_d   = req_dev_addr;
          reg_d   = req_reg_addr[REG_W-1:0];
          wdata_d = req_wdata;
          step_d  = {STEP_W{1'b0}};
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over a timeout in the same cycle
        if (eng_done) begin
          if (step_q == last_step_s) begin
            state_d = ST_RESP;
          end else begin
            step_d  = step_q + STEP_ONE;
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == CNT_TO) begin
          state_d = ST_ERR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values, derived from the next state so outputs are registered
  // yet aligned with the state they belong to.
  always_comb begin
    step_word_s     = step_cmd(step_d, rw_d, dev_d, reg_d, wdata_d);
    req_ready_d     = (state_d == ST_IDLE);
    eng_cmd_valid_d = (state_d == ST_ISSUE);
    rsp_valid_d     = (state_d == ST_RESP) || (state_d == ST_ERR);
    rsp_err_d       = (state_d == ST_ERR);
    eng_cmd_d       = eng_cmd_q;
    eng_wdata_d     = eng_wdata_q;
    rsp_rdata_d     = 8'h00;
    if (state_d == ST_ISSUE) begin
      eng_cmd_d   = step_word_s[13:8];
      eng_wdata_d = step_word_s[7:0];
    end else begin
      eng_cmd_d   = eng_cmd_q;
      eng_wdata_d = eng_wdata_q;
    end
    // RESP is only entered on the final done, so eng_rdata is the read byte now.
    if ((state_d == ST_RESP) && rw_q) begin
      rsp_rdata_d = eng_rdata;
    end else begin
      rsp_rdata_d = 8'h00;
    end
  end

  // State, context and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      step_q          <= {STEP_W{1'b0}};
      cnt_q           <= {CNT_W{1'b0}};
      rw_q            <= 1'b0;
      dev_q           <= 7'h00;
      reg_q           <= {REG_W{1'b0}};
      wdata_q         <= 8'h00;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= 8'h00;
      eng_cmd_valid_q <= 1'b0;
      eng_cmd_q       <= 6'h00;
      eng_wdata_q     <= 8'h00;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      cnt_q           <= cnt_d;
      rw_q            <= rw_d;
      dev_q           <= dev_d;
      reg_q           <= reg_d;
      wdata_q         <= wdata_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_rdata_q     <= rsp_rdata_d;
      eng_cmd_valid_q <= eng_cmd_valid_d;
      eng_cmd_q       <= eng_cmd_d;
      eng_wdata_q     <= eng_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign eng_cmd_valid = eng_cmd_valid_q;
  assign eng_cmd       = eng_cmd_q;
  assign eng_wdata     = eng_wdata_q;

endmodule
